spi_slave_rx_buffer: RTL and testbench
======================================

# spi_slave_rx_buffer

Synchronous receive buffer in the `axi_aclk` domain. It sits between the SPI-to-AXI word synchronizer and the AXI master plug's `rx_data`/`rx_valid`/`rx_ready` port. The SPI side cannot be back-pressured, so the block absorbs write-word bursts while AXI writes are outstanding. It reports fill level and overflow, and drops words it cannot store.

## Interface
Parameters:
- `DATA_WIDTH`, 32: word width; must match the plug's data width.
- `DEPTH`, 8: number of entries; a power of two, ≥ 2.
- `CNT_WIDTH`, $clog2(DEPTH)+1: width of the fill-level output.

Ports:
- `axi_aclk`  in  1  the block's only clock.
- `axi_aresetn`  in  1  reset, asynchronous, active-low.
- `in_data`  in  DATA_WIDTH  word from the synchronizer.
- `in_valid`  in  1  single-cycle push strobe; there is no ready signal.
- `rx_data`  out  DATA_WIDTH  head word (first-word fall-through).
- `rx_valid`  out  1  head word valid.
- `rx_ready`  in  1  pop strobe from the plug.
- `flush`  in  1  synchronous clear of contents (asserted at transfer start).
- `clr_overflow`  in  1  clears `overflow` and `drop_count`.
- `count`  out  CNT_WIDTH  current fill level, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `overflow`  out  1  sticky: at least one word was dropped.
- `drop_count`  out  8  number of dropped words, saturating at 255.

## Operation
- Storage: DEPTH × DATA_WIDTH register array. Pointers `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits and wrap naturally. `count` is a separate registered counter.
- Push: occurs when `in_valid` is high and (not `full`, or a pop happens in the same cycle). The word is written at `wr_ptr`, then `wr_ptr` increments.
- Pop: occurs when `rx_valid` and `rx_ready` are both high. `rd_ptr` increments. `rx_ready` while empty is ignored.
- Push and pop in the same cycle:
  - `count` is unchanged.
  - This holds even when full: the slot freed by the pop is reused, and no drop occurs.
- Drop: `in_valid` while full with no simultaneous pop.
  - The word is discarded.
  - `overflow` is set to 1.
  - `drop_count` increments, saturating at 255.
- `flush`:
  - Resets both pointers and `count` to 0 and overrides any push or pop in the same cycle.
  - Leaves `overflow` and `drop_count` unchanged.
- `clr_overflow`:
  - Clears `overflow` and `drop_count` to 0.
  - A drop in the same cycle wins: `overflow` becomes 1 and `drop_count` becomes 1.
- `rx_data` is the combinational read of `mem[rd_ptr]`. `rx_valid` equals `!empty`.

## Timing
- All of the following are 0 during and after reset: `rx_valid`, `count`, `overflow`, `drop_count`, both pointers. `empty` is 1 and `full` is 0. Memory contents are not reset.
- Assertion of `axi_aresetn` mid-burst clears all state immediately. Stored words are lost.
- Latency: a push in cycle N makes `rx_valid` and `rx_data` visible in cycle N+1. Words never bypass the array combinationally.
- A pop in cycle N presents the next word, or drops `rx_valid`, in cycle N+1.
- `count`, `full`, `empty` and `overflow` are all registered and change in the cycle after the causing edge.
- Throughput: one push and one pop per cycle, sustained.
- Order: strict FIFO. Dropped words leave no gap in the surviving stream.

## Structure
- Shared package `spi_slave_pkg`:
  - `DROP_CNT_WIDTH = 8`
  - default `RX_BUF_DEPTH`
  - typedef `rx_word_t` (`logic [DATA_WIDTH-1:0]`)
- One sub-module, `spi_slave_fifo_mem`: a flop array with one write port and one asynchronous read port. It is reused later for a TX prefetch buffer.
- Pointer, counter and flag logic stay in this module.
- Elaboration-time assertion: `DEPTH` is a power of two and ≥ 2.

## Test plan
- **Reset/empty:** after reset, `rx_ready` = 1 with no push → `rx_valid` = 0, `count` = 0, `empty` = 1 throughout.
- **Basic order:** push 0xA5A5_0001..0xA5A5_0005 on consecutive cycles with `rx_ready` = 0, then `rx_ready` = 1 → `count` peaks at 5, words pop in order, `empty` = 1 after the 5th pop.
- **Overflow:** DEPTH = 8, push 10 words with `rx_ready` = 0 → `full` = 1, `overflow` = 1, `drop_count` = 2, pops return words 1–8 only. `clr_overflow` → both flags are 0.
- **Full with simultaneous push/pop:** fill to 8, then push 0xDEAD_BEEF with `rx_ready` = 1 in the same cycle → `count` stays 8, `overflow` = 0, 0xDEAD_BEEF is the last word popped.
- **Flush priority:** 3 words stored, then `flush`, push and pop in the same cycle → next cycle `count` = 0, `rx_valid` = 0, and the pushed word is never popped.
- **Wrap and saturation:** random push/pop for 1000 cycles against a queue model with zero mismatches, pointers wrapping many times. A further 300 drops → `drop_count` = 255.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave datapath.
package spi_slave_pkg;
  localparam int DROP_CNT_WIDTH = 8;
  localparam int RX_BUF_DEPTH   = 8;
  localparam int RX_DATA_WIDTH  = 32;

  typedef logic [RX_DATA_WIDTH-1:0] rx_word_t;
endpackage

// File: rtl/spi_slave_fifo_mem.sv
// Flop array with one synchronous write port and one asynchronous read port.
// Write lands on the next edge; read is combinational; no flow control of its own.
module spi_slave_fifo_mem #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/spi_slave_rx_buffer.sv
// SPI receive FIFO: first-word fall-through, push visible one cycle later.
// No backpressure to the SPI side: pushes while full without a pop are dropped and counted.
module spi_slave_rx_buffer
  import spi_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = RX_BUF_DEPTH,
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                      axi_aclk,
  input  logic                      axi_aresetn,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_valid,
  output logic [DATA_WIDTH-1:0]     rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  input  logic                      flush,
  input  logic                      clr_overflow,
  output logic [CNT_WIDTH-1:0]      count,
  output logic                      full,
  output logic                      empty,
  output logic                      overflow,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);
  localparam int PTR_W = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("spi_slave_rx_buffer: DEPTH must be a power of two and at least 2");
  end

  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [CNT_WIDTH-1:0]      count_q, count_nxt;
  logic                      full_q, empty_q, overflow_q;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;
  logic                      pop, push, drop;

  // A pop frees the slot the same-cycle push reuses, so full plus pop still accepts.
  assign pop  = !empty_q && rx_ready;
  assign push = in_valid && (!full_q || pop);
  assign drop = in_valid && full_q && !pop && !flush;

  always_comb begin
    count_nxt = count_q;
    if (push && !pop)      count_nxt = count_q + CNT_WIDTH'(1);
    else if (pop && !push) count_nxt = count_q - CNT_WIDTH'(1);
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_nxt;
      full_q  <= (count_nxt == CNT_WIDTH'(DEPTH));
      empty_q <= (count_nxt == '0);
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (clr_overflow)      drop_cnt_q <= DROP_CNT_WIDTH'(1);
      else if (~&drop_cnt_q) drop_cnt_q <= drop_cnt_q + DROP_CNT_WIDTH'(1);
    end else if (clr_overflow) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end
  end

  spi_slave_fifo_mem #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (axi_aclk),
    .we    (push && !flush),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (rx_data)
  );

  assign rx_valid   = !empty_q;
  assign count      = count_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;
endmodule

// File: tb/tb_spi_slave_rx_buffer.sv
// Directed bench for spi_slave_rx_buffer with a queue model for the random phase.
module tb_spi_slave_rx_buffer;
  logic        axi_aclk = 1'b0;
  logic        axi_aresetn;
  logic [31:0] in_data;
  logic        in_valid;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        flush;
  logic        clr_overflow;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;

  always #5 axi_aclk = ~axi_aclk;

  spi_slave_rx_buffer #(.DATA_WIDTH(32), .DEPTH(8)) dut (
    .axi_aclk     (axi_aclk),
    .axi_aresetn  (axi_aresetn),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .flush        (flush),
    .clr_overflow (clr_overflow),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic fill(input logic [31:0] base, input int n);
    rx_ready = 1'b0;
    for (int i = 1; i <= n; i++) begin
      in_data  = base + i;
      in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
  endtask

  logic [31:0] q[$];
  bit          m_pop, m_push;

  initial begin
    axi_aresetn = 1'b0; in_data = '0; in_valid = 1'b0; rx_ready = 1'b0;
    flush = 1'b0; clr_overflow = 1'b0;
    cyc(); cyc();
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    axi_aresetn = 1'b1;

    // Idle with ready high: nothing appears
    rx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("idle_rx_valid", 32'(rx_valid), 32'd0);
      chk("idle_count", 32'(count), 32'd0);
      chk("idle_empty", 32'(empty), 32'd1);
    end

    // Basic order
    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in_data = 32'hA5A5_0000 + i; in_valid = 1'b1;
      cyc();
      chk("basic_count", 32'(count), 32'(i));
      chk("basic_valid", 32'(rx_valid), 32'd1);
      chk("basic_head", rx_data, 32'hA5A5_0001);
    end
    in_valid = 1'b0;
    rx_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      chk("basic_pop_data", rx_data, 32'hA5A5_0000 + i);
      cyc();
      chk("basic_pop_count", 32'(count), 32'(5 - i));
    end
    chk("basic_empty", 32'(empty), 32'd1);
    chk("basic_valid_low", 32'(rx_valid), 32'd0);

    // Overflow: 10 pushes into 8 entries
    fill(32'h0000_1000, 10);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drop", 32'(drop_count), 32'd2);
    rx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("ovf_pop_data", rx_data, 32'h0000_1000 + i);
      cyc();
    end
    chk("ovf_empty", 32'(empty), 32'd1);
    rx_ready = 1'b0;
    clr_overflow = 1'b1; cyc(); clr_overflow = 1'b0;
    chk("clr_flag", 32'(overflow), 32'd0);
    chk("clr_drop", 32'(drop_count), 32'd0);

    // Full with simultaneous push and pop
    fill(32'h0000_2000, 8);
    chk("fpp_full_before", 32'(full), 32'd1);
    chk("fpp_head", rx_data, 32'h0000_2001);
    in_data = 32'hDEAD_BEEF; in_valid = 1'b1; rx_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("fpp_count", 32'(count), 32'd8);
    chk("fpp_full", 32'(full), 32'd1);
    chk("fpp_overflow", 32'(overflow), 32'd0);
    for (int i = 2; i <= 8; i++) begin
      chk("fpp_pop_data", rx_data, 32'h0000_2000 + i);
      cyc();
    end
    chk("fpp_last", rx_data, 32'hDEAD_BEEF);
    cyc();
    chk("fpp_empty", 32'(empty), 32'd1);

    // Flush beats same-cycle push and pop
    fill(32'h0000_3000, 3);
    chk("fl_count_before", 32'(count), 32'd3);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hBAD0_BAD0; rx_ready = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_valid", 32'(rx_valid), 32'd0);
    chk("fl_empty", 32'(empty), 32'd1);
    cyc();
    chk("fl_still_empty", 32'(rx_valid), 32'd0);

    // Drop and clear in the same cycle: the drop wins
    fill(32'h0000_4000, 8);
    in_valid = 1'b1; clr_overflow = 1'b1;
    cyc();
    in_valid = 1'b0; clr_overflow = 1'b0;
    chk("dc_overflow", 32'(overflow), 32'd1);
    chk("dc_drop", 32'(drop_count), 32'd1);
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("fl_keeps_overflow", 32'(overflow), 32'd1);
    chk("fl_keeps_drop", 32'(drop_count), 32'd1);
    clr_overflow = 1'b1; cyc(); clr_overflow = 1'b0;

    // Random traffic against a queue model
    for (int c = 0; c < 1000; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      rx_ready = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      m_pop  = (q.size() > 0) && rx_ready;
      m_push = in_valid && ((q.size() < 8) || m_pop);
      if (q.size() > 0) chk("rnd_head", rx_data, q[0]);
      if (m_pop)  void'(q.pop_front());
      if (m_push) q.push_back(in_data);
      cyc();
      chk("rnd_count", 32'(count), 32'(q.size()));
      chk("rnd_valid", 32'(rx_valid), 32'(q.size() > 0));
    end
    in_valid = 1'b0; rx_ready = 1'b0;
    flush = 1'b1; clr_overflow = 1'b1; cyc(); flush = 1'b0; clr_overflow = 1'b0;
    q.delete();

    // Drop counter saturation
    fill(32'h0000_5000, 8);
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) cyc();
    in_valid = 1'b0;
    chk("sat_drop", 32'(drop_count), 32'd255);
    chk("sat_overflow", 32'(overflow), 32'd1);
    chk("sat_head", rx_data, 32'h0000_5001);

    // Asynchronous reset mid-burst clears state without a clock edge
    flush = 1'b1; cyc(); flush = 1'b0;
    fill(32'h0000_6000, 4);
    @(negedge axi_aclk);
    axi_aresetn = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_valid", 32'(rx_valid), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_drop", 32'(drop_count), 32'd0);
    chk("arst_overflow", 32'(overflow), 32'd0);
    cyc();
    axi_aresetn = 1'b1;
    cyc();
    chk("arst_after", 32'(rx_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
